// File: rtl/memory_round_engine.sv
// memory_round_engine: plays a stored key pattern, judges the player's presses, keeps score/rounds.
// Optional per-press timeout in INPUT is enabled by defining MEM_TIMEOUT_EN.
module memory_round_engine #(
    parameter int unsigned NUM_KEYS    = 8,
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned LEN_LV1     = 4,
    parameter int unsigned LEN_LV2     = 6,
    parameter int unsigned LEN_LV3     = 8,
    parameter int unsigned NUM_ROUNDS  = 5,
    parameter int unsigned SHOW_CYC    = 4,
    parameter int unsigned GAP_CYC     = 2,
    parameter int unsigned SCORE_W     = 8,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned IDX_W       = $clog2(NUM_KEYS),
    parameter int unsigned RC_W        = $clog2(NUM_ROUNDS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [2:0]                 level,
    input  logic [MAX_LEN*IDX_W-1:0]   pattern_flat,
    input  logic                       pattern_valid,
    output logic                       pattern_req,
    input  logic [NUM_KEYS-1:0]        buttons,
    output logic [NUM_KEYS-1:0]        led,
    output logic [RC_W-1:0]            round_cnt,
    output logic [SCORE_W-1:0]         score,
    output logic                       round_ok,
    output logic                       round_fail,
    output logic                       busy,
    output logic                       game_over
);

    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);
    localparam int unsigned POS_W  = $clog2(MAX_LEN);
    localparam int unsigned SG_MAX = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_MAX = (TIMEOUT_CYC > SG_MAX) ? TIMEOUT_CYC : SG_MAX;
`else
    localparam int unsigned CNT_MAX = SG_MAX;
`endif
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [3:0] StIdle    = 4'd0;
    localparam logic [3:0] StReq     = 4'd1;
    localparam logic [3:0] StWaitPat = 4'd2;
    localparam logic [3:0] StShowOn  = 4'd3;
    localparam logic [3:0] StShowGap = 4'd4;
    localparam logic [3:0] StInput   = 4'd5;
    localparam logic [3:0] StJudge   = 4'd6;
    localparam logic [3:0] StTerm    = 4'd7;
    localparam logic [3:0] StDone    = 4'd8;

    logic [3:0]         state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [POS_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   key_q, key_d;
    logic               bad_q, bad_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [RC_W-1:0]    rc_q, rc_d;

    logic [IDX_W-1:0]    entry;
    logic [NUM_KEYS-1:0] entry_led, key_led;
    logic [IDX_W-1:0]    btn_idx;
    logic [LEN_W-1:0]    lvl_len;
    logic                lvl_ok;
    logic                match, last, timeout;
    logic [SCORE_W:0]    score_sum;

    assign entry     = pattern_flat[idx_q*IDX_W +: IDX_W];
    assign match     = !bad_q && (key_q == entry);
    assign last      = (LEN_W'(idx_q) == len_q - LEN_W'(1));
    assign score_sum = {1'b0, score_q} + (SCORE_W + 1)'(len_q);

`ifdef MEM_TIMEOUT_EN
    // A press arriving on the expiry cycle still wins over the timeout.
    assign timeout = (state_q == StInput) && (buttons == '0) &&
                     (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // Entries >= NUM_KEYS match no channel and therefore light nothing.
    always_comb begin
        entry_led = '0;
        key_led   = '0;
        btn_idx   = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            entry_led[k] = (entry == IDX_W'(k));
            key_led[k]   = (key_q == IDX_W'(k)) && !bad_q;
            if (buttons[k]) btn_idx = IDX_W'(k);
        end
    end

    always_comb begin
        lvl_ok  = 1'b1;
        lvl_len = '0;
        case (level)
            3'b001:  lvl_len = LEN_W'(LEN_LV1);
            3'b010:  lvl_len = LEN_W'(LEN_LV2);
            3'b100:  lvl_len = LEN_W'(LEN_LV3);
            default: lvl_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        bad_d   = bad_q;
        score_d = score_q;
        rc_d    = rc_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start && lvl_ok) begin
                    len_d   = lvl_len;
                    score_d = '0;
                    rc_d    = '0;
                    state_d = StReq;
                end
            end
            StReq: state_d = StWaitPat;
            StWaitPat: begin
                if (pattern_valid) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = StShowOn;
                end
            end
            StShowOn: begin
                if (cnt_q == CNT_W'(SHOW_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = StShowGap;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StShowGap: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    cnt_d = '0;
                    if (last) begin
                        idx_d   = '0;
                        state_d = StInput;
                    end else begin
                        idx_d   = idx_q + POS_W'(1);
                        state_d = StShowOn;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StInput: begin
                if (buttons != '0) begin
                    key_d   = btn_idx;
                    bad_d   = !$onehot(buttons);
                    state_d = StJudge;
                end else if (timeout) begin
                    cnt_d   = '0;
                    state_d = StTerm;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StJudge: begin
                cnt_d = '0;
                if (!match) begin
                    state_d = StTerm;
                end else if (last) begin
                    score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                    state_d = StTerm;
                end else begin
                    idx_d   = idx_q + POS_W'(1);
                    state_d = StInput;
                end
            end
            StTerm: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    rc_d    = rc_q + RC_W'(1);
                    state_d = (rc_q == RC_W'(NUM_ROUNDS - 1)) ? StDone : StReq;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
            bad_q   <= 1'b0;
            score_q <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            bad_q   <= bad_d;
            score_q <= score_d;
            rc_q    <= rc_d;
        end
    end

    always_comb begin
        led = '0;
        if (state_q == StShowOn) led = entry_led;
        else if (state_q == StJudge) led = key_led;
    end

    assign pattern_req = (state_q == StReq);
    assign round_ok    = (state_q == StJudge) && match && last;
    assign round_fail  = ((state_q == StJudge) && !match) || timeout;
    assign busy        = (state_q != StIdle) && (state_q != StDone);
    assign game_over   = (state_q == StDone);
    assign score       = score_q;
    assign round_cnt   = rc_q;

endmodule

// File: tb/tb_memory_round_engine.sv
// Directed-sequence bench for memory_round_engine with randomized patterns/presses and a
// round-level reference model (expected LEDs, verdicts, score and round count).
module tb_memory_round_engine;

    localparam int NK = 8;
    localparam int IW = 3;
    localparam int ML = 16;
    localparam int NR = 5;
    localparam int SW = 5;
    localparam int SHOW = 4;
    localparam int GAP = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [2:0]      level = 3'b000;
    logic [ML*IW-1:0] pattern_flat = '0;
    logic            pattern_valid = 1'b0;
    logic            pattern_req;
    logic [NK-1:0]   buttons = '0;
    logic [NK-1:0]   led;
    logic [2:0]      round_cnt;
    logic [SW-1:0]   score;
    logic            round_ok, round_fail, busy, game_over;

    int checks = 0;
    int failures = 0;
    int exp_score = 0;
    int exp_rounds = 0;

    logic [IW-1:0] pat [ML];
    logic [NK-1:0] press [ML];

    always #5 clk = ~clk;

    memory_round_engine #(.SCORE_W(SW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .level         (level),
        .pattern_flat  (pattern_flat),
        .pattern_valid (pattern_valid),
        .pattern_req   (pattern_req),
        .buttons       (buttons),
        .led           (led),
        .round_cnt     (round_cnt),
        .score         (score),
        .round_ok      (round_ok),
        .round_fail    (round_fail),
        .busy          (busy),
        .game_over     (game_over)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a game with a valid level; DUT must answer with pattern_req one cycle later.
    task automatic do_start(input logic [2:0] lvl);
        start = 1'b1;
        level = lvl;
        @(negedge clk);
        start = 1'b0;
        level = 3'($urandom);
        exp_score = 0;
        exp_rounds = 0;
        check("start_req", pattern_req, 1);
        check("start_busy", busy, 1);
        check("start_score_clr", score, 0);
        check("start_rounds_clr", round_cnt, 0);
    endtask

    task automatic rand_pat(input int len);
        for (int i = 0; i < ML; i++) pat[i] = 3'($urandom_range(0, NK - 1));
    endtask

    // Called at the negedge where pattern_req is high; returns at the first SHOW_ON negedge.
    task automatic handoff();
        for (int i = 0; i < ML; i++) pattern_flat[i*IW +: IW] = pat[i];
        pattern_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pattern_valid = 1'b0;
    endtask

    // Expected playback: each entry lit SHOW cycles then GAP dark cycles. Returns in INPUT.
    task automatic playback(input int len, input bit noise);
        logic [NK-1:0] one;
        one = 1;
        for (int i = 0; i < len; i++) begin
            for (int c = 0; c < SHOW + GAP; c++) begin
                check("show_led", led, (c < SHOW) ? (one << pat[i]) : 0);
                if (noise) begin
                    buttons = NK'($urandom);
                    start = 1'($urandom);
                    level = 3'($urandom);
                end
                @(negedge clk);
            end
        end
        buttons = '0;
        start = 1'b0;
    endtask

    task automatic finish_round();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (pattern_req || game_over) break;
        end
        check("round_end_seen", pattern_req || game_over, 1);
        check("round_cnt", round_cnt, exp_rounds);
        check("score", score, exp_score);
        check("game_over", game_over, exp_rounds == NR);
    endtask

    // Plays one round. wrong_at >= 0 replaces that press by a wrong key (or by a multi-hot press).
    task automatic run_round(input int len, input bit noise, input int wrong_at, input bit multi);
        logic [NK-1:0] one;
        bit pass, ok1, match, lst;
        int w;
        one = 1;
        for (int i = 0; i < len; i++) press[i] = one << pat[i];
        if (wrong_at >= 0) begin
            w = (int'(pat[wrong_at]) + int'($urandom_range(1, NK - 1))) % NK;
            press[wrong_at] = multi ? 8'b0000_0011 : (one << w);
        end
        handoff();
        playback(len, noise);
        pass = 1'b0;
        for (int i = 0; i < len; i++) begin
            buttons = press[i];
            @(negedge clk);
            buttons = '0;
            ok1 = $onehot(press[i]);
            match = ok1 && (press[i] == (one << pat[i]));
            lst = match && (i == len - 1);
            check("echo_led", led, ok1 ? press[i] : 0);
            check("round_ok", round_ok, lst);
            check("round_fail", round_fail, !match);
            if (!match || lst) begin
                pass = lst;
                break;
            end
            @(negedge clk);
        end
        exp_rounds++;
        if (pass) exp_score = (exp_score + len > 31) ? 31 : exp_score + len;
        finish_round();
    endtask

    task automatic timeout_round(input int len);
        logic [NK-1:0] one;
        int fail_at;
        one = 1;
        rand_pat(len);
        handoff();
        playback(len, 1'b0);
        fail_at = -1;
        for (int k = 0; k < 1000; k++) begin
            if (round_fail) begin
                fail_at = k;
                break;
            end
            @(negedge clk);
        end
`ifdef MEM_TIMEOUT_EN
        check("timeout_cycle", fail_at, 63);
`else
        check("no_timeout", fail_at, -1);
        check("still_busy", busy, 1);
        buttons = one << ((int'(pat[0]) + 1) % NK);
        @(negedge clk);
        buttons = '0;
        check("late_wrong_fail", round_fail, 1);
`endif
        exp_rounds++;
        finish_round();
    endtask

    initial begin
        @(negedge clk);
        check("rst_led", led, 0);
        check("rst_busy", busy, 0);
        check("rst_score", score, 0);
        check("rst_rounds", round_cnt, 0);
        check("rst_req", pattern_req, 0);
        check("rst_over", game_over, 0);
        rst = 1'b0;
        @(negedge clk);

        // Multi-hot level is rejected in IDLE.
        start = 1'b1;
        level = 3'b011;
        @(negedge clk);
        start = 1'b0;
        check("bad_lvl_busy", busy, 0);
        check("bad_lvl_req", pattern_req, 0);

        // Game A, level 001: fixed pattern, then noisy/multi-hot/wrong rounds.
        do_start(3'b001);
        rand_pat(4);
        pat[0] = 3'd2; pat[1] = 3'd5; pat[2] = 3'd0; pat[3] = 3'd7;
        run_round(4, 1'b0, -1, 1'b0);
        rand_pat(4);
        run_round(4, 1'b1, -1, 1'b0);
        rand_pat(4);
        run_round(4, 1'b1, 0, 1'b1);
        rand_pat(4);
        run_round(4, 1'b0, 1, 1'b0);
        rand_pat(4);
        run_round(4, 1'b1, -1, 1'b0);

        // Invalid start in DONE leaves results in place.
        start = 1'b1;
        level = 3'b110;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("done_hold_over", game_over, 1);
        check("done_hold_score", score, exp_score);
        check("done_hold_rounds", round_cnt, NR);

        // Game B, level 010: pass, second-press wrong, then reset during playback.
        do_start(3'b010);
        rand_pat(6);
        run_round(6, 1'b0, -1, 1'b0);
        rand_pat(6);
        run_round(6, 1'b1, 1, 1'b0);
        rand_pat(6);
        handoff();
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("amid_rst_led", led, 0);
        check("amid_rst_busy", busy, 0);
        check("amid_rst_score", score, 0);
        check("amid_rst_rounds", round_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", busy, 0);

        // Game C, level 100: five passes saturate the 5-bit score.
        do_start(3'b100);
        for (int r = 0; r < NR; r++) begin
            rand_pat(8);
            run_round(8, 1'b1, -1, 1'b0);
        end
        check("sat_score", score, 31);

        // New game clears results; idle INPUT behaviour depends on the timeout option.
        do_start(3'b001);
        timeout_round(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
